// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the RAM port of mem_arbiter.
// The slave modport is the arbiter's view; master is the environment driving requests and RAM status.
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          r0_REN;
    logic          r0_WEN;
    logic [AW-1:0] r0_addr;
    logic [31:0]   r0_store;
    logic          r0_done;
    logic          r0_err;
    logic [31:0]   r0_load;

    logic          r1_REN;
    logic          r1_WEN;
    logic [AW-1:0] r1_addr;
    logic [31:0]   r1_store;
    logic          r1_done;
    logic          r1_err;
    logic [31:0]   r1_load;

    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [31:0]   ramstore;
    logic [31:0]   ramload;
    logic [1:0]    ramstate;

    logic          busy;

    modport slave (
        input  r0_REN, r0_WEN, r0_addr, r0_store,
        input  r1_REN, r1_WEN, r1_addr, r1_store,
        input  ramload, ramstate,
        output r0_done, r0_err, r0_load,
        output r1_done, r1_err, r1_load,
        output ramREN, ramWEN, ramaddr, ramstore,
        output busy
    );

    modport master (
        output r0_REN, r0_WEN, r0_addr, r0_store,
        output r1_REN, r1_WEN, r1_addr, r1_store,
        output ramload, ramstate,
        input  r0_done, r0_err, r0_load,
        input  r1_done, r1_err, r1_load,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single RAM port, with per-access timeout.
// Handshake: rN_REN/rN_WEN are held until a one-cycle rN_done or rN_err pulse; the RAM sees one request at a time.
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic           CLK,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic [1:0]     dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DONE} state_t;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;
    localparam int         CW        = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          wen_q, wen_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic [31:0]   load_q, load_d;

    logic v0, v1, win, granted, access, abort, err_now;

    always_comb begin
        v0      = bus.r0_REN | bus.r0_WEN;
        v1      = bus.r1_REN | bus.r1_WEN;
        win     = (v0 && v1) ? ~last_q : v1;
        granted = (state_q == S_GRANT);
        access  = (bus.ramstate == RS_ACCESS);
        // ACCESS wins over a timeout landing on the same cycle
        abort   = granted && !access && ((bus.ramstate == RS_ERROR) || (cnt_q == CNT_LAST));
        err_now = abort && !rst;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        store_d = store_q;
        load_d  = load_q;
        case (state_q)
            S_IDLE: begin
                if (v0 || v1) begin
                    gnt_d   = win;
                    addr_d  = win ? bus.r1_addr  : bus.r0_addr;
                    store_d = win ? bus.r1_store : bus.r0_store;
                    wen_d   = win ? bus.r1_WEN   : bus.r0_WEN;
                    cnt_d   = '0;
                    load_d  = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (access) begin
                    if (!wen_q) load_d = bus.ramload;
                    last_d  = gnt_q;
                    state_d = S_DONE;
                end else if (abort) begin
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            load_q  <= load_d;
        end
    end

    assign bus.ramREN   = granted & ~wen_q;
    assign bus.ramWEN   = granted & wen_q;
    assign bus.ramaddr  = granted ? addr_q  : '0;
    assign bus.ramstore = granted ? store_q : '0;

    assign bus.r0_done  = (state_q == S_DONE) & ~gnt_q;
    assign bus.r1_done  = (state_q == S_DONE) & gnt_q;
    assign bus.r0_load  = bus.r0_done ? load_q : '0;
    assign bus.r1_load  = bus.r1_done ? load_q : '0;
    assign bus.r0_err   = err_now & ~gnt_q;
    assign bus.r1_err   = err_now & gnt_q;

    assign bus.busy     = (state_q != S_IDLE);
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int TIMEOUT = 16;
  localparam int AW      = 32;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        d0;
    logic        e0;
    logic [31:0] l0;
    logic        d1;
    logic        e1;
    logic [31:0] l1;
    logic        busy;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AW(AW)) bus ();

  mem_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int n, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      bus.r0_REN = ren; bus.r0_WEN = wen; bus.r0_addr = a; bus.r0_store = d;
    end else begin
      bus.r1_REN = ren; bus.r1_WEN = wen; bus.r1_addr = a; bus.r1_store = d;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding access: who owns the RAM, how long it has waited,
  // and whether it has completed and is now reporting its result.
  bit          m_valid = 0;
  int          m_owner = -1;
  bit          m_fin   = 0;
  int          m_wait  = 0;
  bit          m_wr    = 0;
  logic [31:0] m_addr, m_store, m_result;
  int          m_prev  = 1;
  obs_t        e_obs, a_obs;
  bit          w0, w1;
  int          pick;

  always @(negedge CLK) begin
    a_obs = {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore,
             bus.r0_done, bus.r0_err, bus.r0_load,
             bus.r1_done, bus.r1_err, bus.r1_load, bus.busy};
    if (m_valid) begin
      e_obs = '0;
      if (m_owner >= 0) begin
        e_obs.busy = 1'b1;
        if (m_fin) begin
          if (m_owner == 0) begin e_obs.d0 = 1'b1; e_obs.l0 = m_result; end
          else begin e_obs.d1 = 1'b1; e_obs.l1 = m_result; end
        end else begin
          e_obs.ren   = !m_wr;
          e_obs.wen   = m_wr;
          e_obs.addr  = m_addr;
          e_obs.store = m_store;
          if (!rst && bus.ramstate != ACCESS &&
              (bus.ramstate == ERROR || m_wait == TIMEOUT - 1)) begin
            if (m_owner == 0) e_obs.e0 = 1'b1; else e_obs.e1 = 1'b1;
          end
        end
      end
      n_cmp++;
      if (a_obs !== e_obs) begin
        n_bad++;
        $display("FAIL cycle_outputs at %0t: got %h expected %h", $time, a_obs, e_obs);
      end
    end
    // advance the model to what the next edge makes of these inputs
    if (rst) begin
      m_valid = 1; m_owner = -1; m_fin = 0; m_prev = 1; m_wait = 0;
    end else if (m_valid) begin
      if (m_owner >= 0 && m_fin) begin
        m_owner = -1; m_fin = 0;
      end else if (m_owner >= 0) begin
        if (bus.ramstate == ACCESS) begin
          m_result = m_wr ? 32'h0 : bus.ramload;
          m_fin = 1; m_prev = m_owner;
        end else if (bus.ramstate == ERROR || m_wait == TIMEOUT - 1) begin
          m_prev = m_owner; m_owner = -1;
        end else begin
          m_wait++;
        end
      end else begin
        w0 = bus.r0_REN | bus.r0_WEN;
        w1 = bus.r1_REN | bus.r1_WEN;
        pick = -1;
        if (w0 && w1) pick = 1 - m_prev;
        else if (w0)  pick = 0;
        else if (w1)  pick = 1;
        if (pick == 0) begin
          m_owner = 0; m_wait = 0; m_wr = bus.r0_WEN; m_addr = bus.r0_addr; m_store = bus.r0_store;
        end else if (pick == 1) begin
          m_owner = 1; m_wait = 0; m_wr = bus.r1_WEN; m_addr = bus.r1_addr; m_store = bus.r1_store;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          stable, errc, ngr;
  bit          saw_done;
  int          order[$];
  bit          active[2];
  bit          seen[2];
  int          r, op;

  task automatic start_random(input int n);
    op = $urandom_range(0, 3);
    set_req(n, op != 2, op >= 2, $urandom(), $urandom());
    active[n] = 1;
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.ramstate = FREE;
    bus.ramload  = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge CLK);
    check("reset_busy",  32'(bus.busy), 0);
    check("reset_ramen", 32'({bus.ramREN, bus.ramWEN}), 0);
    check("reset_pulse", 32'({bus.r0_done, bus.r0_err, bus.r1_done, bus.r1_err}), 0);
    check("reset_state", 32'(dbg_state), 0);

    // single read with immediate ACCESS
    tick(); set_req(0, 1, 0, 32'h40, 0);
    @(negedge CLK); check("rd_idle_ren", 32'(bus.ramREN), 0);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    @(negedge CLK);
    check("rd_grant_ren", 32'(bus.ramREN), 1);
    check("rd_grant_addr", bus.ramaddr, 32'h40);
    tick(); bus.ramstate = FREE; bus.ramload = 0;
    @(negedge CLK);
    check("rd_done", 32'(bus.r0_done), 1);
    check("rd_load", bus.r0_load, 32'hDEADBEEF);
    tick(); set_req(0, 0, 0, 0, 0);
    @(negedge CLK); check("rd_back_idle", 32'(bus.busy), 0);

    // write stretched by five BUSY cycles
    tick(); set_req(1, 0, 1, 32'h10, 32'h12345678);
    @(negedge CLK);
    tick();
    stable = 0;
    for (int k = 0; k < 6; k++) begin
      bus.ramstate = (k < 5) ? BUSY : ACCESS;
      @(negedge CLK);
      if (bus.ramWEN && !bus.ramREN && bus.ramaddr == 32'h10 && bus.ramstore == 32'h12345678)
        stable++;
      tick();
    end
    bus.ramstate = FREE;
    check("wr_stable_cycles", stable, 6);
    @(negedge CLK);
    check("wr_done", 32'(bus.r1_done), 1);
    check("wr_load", bus.r1_load, 0);
    tick(); set_req(1, 0, 0, 0, 0);

    // timeout abort, then r1 must win over a still-high r0
    set_req(0, 1, 0, 32'h80, 0);
    @(negedge CLK);
    errc = -1; saw_done = 0;
    for (int k = 1; k <= 24 && errc < 0; k++) begin
      tick();
      if (k == 2) set_req(1, 1, 0, 32'h90, 0);
      @(negedge CLK);
      if (bus.r0_done) saw_done = 1;
      if (bus.r0_err) errc = k;
    end
    check("to_err_latency", errc, 16);
    check("to_no_done", 32'(saw_done), 0);
    tick();
    @(negedge CLK);
    tick(); set_req(0, 0, 0, 0, 0); bus.ramstate = ACCESS; bus.ramload = 32'h5555AAAA;
    @(negedge CLK);
    check("to_r1_next_ren", 32'(bus.ramREN), 1);
    check("to_r1_next_addr", bus.ramaddr, 32'h90);
    tick(); bus.ramstate = FREE;
    @(negedge CLK);
    check("to_r1_done", 32'(bus.r1_done), 1);
    check("to_r1_load", bus.r1_load, 32'h5555AAAA);
    tick(); set_req(1, 0, 0, 0, 0);

    // continuous contention from reset alternates grants
    rst = 1'b1; tick(); rst = 1'b0;
    set_req(0, 1, 0, 32'h100, 0);
    set_req(1, 1, 0, 32'h200, 0);
    bus.ramstate = ACCESS;
    order.delete();
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (bus.ramREN) order.push_back(bus.ramaddr == 32'h200 ? 1 : 0);
      tick();
    end
    check("rr_grants", order.size() >= 4 ? 1 : 0, 1);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check($sformatf("rr_order_%0d", i), order[i], i % 2);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick(); tick(); tick();
    bus.ramstate = FREE;

    // reset on the third GRANT cycle
    set_req(0, 1, 0, 32'h44, 0); bus.ramstate = BUSY;
    @(negedge CLK);
    tick(); tick(); tick(); rst = 1'b1;
    @(negedge CLK);
    check("rst_g3_err", 32'(bus.r0_err), 0);
    tick(); rst = 1'b0;
    @(negedge CLK);
    check("rst_after_outs", 32'({bus.ramREN, bus.ramWEN, bus.busy, bus.r0_done, bus.r0_err}), 0);
    check("rst_after_addr", bus.ramaddr, 0);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0001;
    @(negedge CLK);
    check("rst_fresh_grant", 32'(bus.ramREN), 1);
    tick(); bus.ramstate = FREE;
    @(negedge CLK);
    check("rst_fresh_done", bus.r0_load, 32'hCAFE0001);
    tick(); set_req(0, 0, 0, 0, 0);

    // REN and WEN together is a write
    set_req(0, 1, 1, 32'h48, 32'hA5A5A5A5);
    @(negedge CLK);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hFFFFFFFF;
    @(negedge CLK);
    check("both_op", 32'({bus.ramREN, bus.ramWEN}), 32'b01);
    check("both_store", bus.ramstore, 32'hA5A5A5A5);
    tick(); bus.ramstate = FREE;
    @(negedge CLK);
    check("both_load", bus.r0_load, 0);
    tick(); set_req(0, 0, 0, 0, 0);

    // randomized traffic, alternating access-heavy and stall-heavy RAM behaviour
    active[0] = 0; active[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      seen[0] = bus.r0_done | bus.r0_err;
      seen[1] = bus.r1_done | bus.r1_err;
      tick();
      rst = ($urandom_range(0, 599) == 0);
      for (int n = 0; n < 2; n++) begin
        if (rst) begin
          set_req(n, 0, 0, 0, 0); active[n] = 0;
        end else if (active[n] && (seen[n] || $urandom_range(0, 99) == 0)) begin
          set_req(n, 0, 0, 0, 0); active[n] = 0;
          if ($urandom_range(0, 3) == 0) start_random(n);
        end else if (!active[n] && $urandom_range(0, 2) == 0) begin
          start_random(n);
        end
      end
      r = $urandom_range(0, 99);
      if (((c / 300) % 2) == 1)
        bus.ramstate = (r < 3) ? ACCESS : (r < 5) ? ERROR : (r < 50) ? FREE : BUSY;
      else
        bus.ramstate = (r < 40) ? ACCESS : (r < 48) ? ERROR : (r < 74) ? FREE : BUSY;
      bus.ramload = $urandom();
    end
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    bus.ramstate = ACCESS;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, limit 2000000 reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a grant may wait for ramstate ACCESS before aborting.
REQ-002 Parameter AW, default 32: address width; data width is fixed at 32.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rN_REN, rN_WEN  in  1 each  read/write request from requester N (N=0 scheduler core, N=1 tensor-core DMA); held until rN_done or rN_err.
REQ-006 rN_addr  in  AW,  rN_store  in  32  access address and write data; stable while the request is held.
REQ-007 rN_done  out  1  one-cycle completion pulse;  rN_err  out  1  one-cycle abort pulse;  rN_load  out  32  read data, valid while rN_done=1.
REQ-008 ramREN, ramWEN  out  1 each;  ramaddr  out  AW;  ramstore  out  32  RAM request port.
REQ-009 ramload  in  32  RAM read data;  ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
REQ-010 busy  out  1  high in any state other than IDLE.

Function
REQ-011 FSM states: IDLE, GRANT, DONE.
REQ-012 IDLE: a requester is valid when REN or WEN is high; if rN_REN and rN_WEN are both high, the request is treated as a write.
REQ-013 IDLE, with one or more valid requesters: register the winner into gnt, latch its addr, store and op, clear the timeout counter, and go to GRANT on the next edge.
REQ-014 Arbitration is round-robin: winner = valid requester != last; if only one requester is valid, it wins; last resets to 1, so requester 0 wins the first contention.
REQ-015 GRANT: drive ramREN/ramWEN, ramaddr and ramstore from the latched values; all RAM outputs are 0 in IDLE and DONE.
REQ-016 GRANT, ramstate=ACCESS: latch ramload (reads only), set last=gnt, go to DONE.
REQ-017 GRANT, ramstate=ERROR, or timeout counter reaching TIMEOUT-1: pulse rN_err for gnt for one cycle, set last=gnt, go to IDLE; the RAM request drops the same edge.
REQ-018 GRANT, ramstate FREE or BUSY: increment the counter and hold the request.
REQ-019 DONE: for gnt, rN_done=1 and rN_load=latched data (0 for writes) for exactly one cycle, then go to IDLE.
REQ-020 Requester-to-RAM latency is 1 cycle; ACCESS-to-done latency is 1 cycle; the minimum access takes 3 cycles from IDLE back to IDLE.
REQ-021 Back-to-back: a requester that drops its request in the cycle after done is not re-granted; a request still high in IDLE is treated as a new access.
REQ-022 A non-granted requester's done and err stay 0; its request is ignored until the FSM returns to IDLE.
REQ-023 A request deasserted while granted does not cancel the access; the access still completes or aborts normally.
REQ-024 Timeout counter width is clog2(TIMEOUT)+1 bits and never wraps; it clears on every entry to GRANT.

Reset
REQ-025 rst=1 at an edge: state=IDLE, last=1, counter=0, latches=0.
REQ-026 Outputs during reset: ramREN, ramWEN, ramaddr, ramstore, rN_done, rN_err, rN_load and busy all 0.
REQ-027 rst asserted mid-GRANT abandons the access with no done or err pulse; the RAM request drops the edge after rst is sampled.

Verification
REQ-028 r0 read addr 0x40, ramstate ACCESS one cycle after grant with ramload=0xDEADBEEF -> ramREN high 1 cycle later, r0_done pulses 1 cycle with r0_load=0xDEADBEEF, then IDLE.
REQ-029 r0 and r1 both request reads continuously from reset -> grants alternate 0,1,0,1; no requester waits more than one access.
REQ-030 r1 write addr 0x10 data 0x12345678, ramstate BUSY for 5 cycles then ACCESS -> ramWEN/ramaddr/ramstore stable for 6 cycles, then r1_done, r1_load=0.
REQ-031 ramstate held FREE, TIMEOUT=16 -> r0_err pulses 16 cycles after grant, no done, and r1 is granted next if pending.
REQ-032 rst pulsed on the 3rd GRANT cycle -> all outputs 0 next cycle, no done or err, and the next request gets a fresh grant.
REQ-033 r0 REN and WEN both high -> write is performed (ramWEN=1, ramREN=0).
